ldpc_3gpp_enc_p1_rot: RTL
=========================

// Module: ldpc_3gpp_enc_p1_rot
// PURPOSE
// - Next-generation p1 stage of the 3GPP LDPC encoder: buffers one frame of pN_ROW core-parity syndrome blocks
//   (E*T^-1*A*u' + C*u'), multiplies it by the invPsi quasi-cyclic matrix, and emits pN_ROW p1 blocks.
// - Runs the block-circulant multiply internally (one rotate+XOR per cycle) with run-time Zc, per-frame latched mode/matrix.
// - Feeds the output buffer and the p2 stage (A*u' update) from a single registered result.
// PARAMETERS
// - pN_ROW    4   core parity blocks per frame (matrix is pN_ROW x pN_ROW); >=1
// - pZC_W     384 max expansion factor = data word width in bits
// - pZC_LW    9   width of iused_zc and of each shift field; 2**pZC_LW > pZC_W
// - pSHIFT_R  1   1: rotate right (y[k]=x[(k+s) mod Zc]); 0: rotate left
// PORTS
// - iclk      in  1                          clock
// - ireset    in  1                          reset, asynchronous, active-high
// - iclkena   in  1                          clock enable; 0 freezes all state and outputs
// - iused_zc  in  pZC_LW                     used Zc, 2..pZC_W; latched at frame start
// - ibypass   in  1                          invPsi == identity for this code; latched at frame start
// - iinvPsi   in  pN_ROW*pN_ROW*(1+pZC_LW)   entry [j][i] = {valid, shift}, j-major, latched at frame start
// - iwrite    in  1                          input word valid
// - iwstart   in  1                          first word of frame (qualified by iwrite)
// - iwdat     in  pZC_W                      syndrome block, bits [Zc-1:0] used
// - ordy      out 1                          1 in IDLE/LOAD; writes with ordy=0 are dropped
// - obusy     out 1                          state != IDLE
// - oval      out 1                          p1 block valid
// - osof/oeof out 1                          first / last p1 block of frame
// - oidx      out $clog2(pN_ROW) (min 1)     p1 block index j
// - odat      out pZC_W                      p1 block; bits >= Zc are zero
// - owrite2p2/owstart2p2/owdat2p2 out 1/1/pZC_W  == oval/osof/odat
// - oerr      out 1                          sticky: shift >= Zc seen or frame restarted; cleared by reset only
// BEHAVIOUR
// - Reset: state IDLE, all counters 0, oval/osof/oeof/oerr 0, ordy 1, obusy 0; odat/oidx don't care.
// - FSM IDLE -> LOAD -> (CALC | IDLE) -> IDLE; all transitions gated by iclkena.
// - IDLE: iwrite&iwstart stores word 0, latches zc/bypass/invPsi, goes LOAD with wcnt=1. iwrite without iwstart ignored.
// - LOAD: each iwrite stores word wcnt, wcnt++. iwrite&iwstart restarts frame (word 0, relatch, set oerr).
//   On the pN_ROW-th word: bypass -> IDLE; else -> CALC, ordy=0 from next cycle.
// - Bypass: each accepted word k emitted next cycle: oval=1, oidx=k, osof=(k==0), oeof=(k==pN_ROW-1), odat=masked word.
// - CALC: row j, col i counters, i inner; per cycle acc ^= term(j,i); term = valid ? rot(s[i], shift) : 0.
//   At i==pN_ROW-1: next cycle oval=1, odat=acc^term, oidx=j, acc cleared; after j==pN_ROW-1 -> IDLE, ordy=1.
//   CALC lasts pN_ROW*pN_ROW cycles; row j output at CALC entry + (j+1)*pN_ROW cycles; oval one-cycle pulses.
// - rot: d = x_masked | (x_masked << Zc) (2*pZC_W wide); right: (d >> s) & mask(Zc); left: rot right by Zc-s (s==0 -> x).
// - shift >= Zc on a valid entry: term = 0, oerr set.
// - New frame accepted the cycle after the last CALC output is issued (IDLE); no overlap of frames.
// - Reset mid-frame: immediate return to IDLE, partial frame discarded, no oval.
// STRUCTURE
// - Package ldpc_3gpp_enc_p1_rot_pkg: invpsi_entry_t {valid, shift}, state_t enum, helper function for Zc mask.
// - Sub-module ldpc_3gpp_enc_zc_rot: combinational variable-Zc cyclic rotator (pZC_W, pZC_LW, pSHIFT_R);
//   registered pipeline stays in the parent.
// - Parent: word buffer pN_ROW x pZC_W, latched config regs, FSM, counters, accumulator, output regs.
// TESTING
// - pZC_W=16, Zc=8, bypass=1, words 01,02,04,08 -> oval 1 cycle after each, oidx 0..3, osof on 0, oeof on 3, data equal.
// - Zc=8, invPsi=identity (valid diag, shift 0), bypass=0, words 11,22,44,88 -> same data 4,8,12,16 cycles after CALC entry.
// - Zc=8, single entry [0][0]={1,3}, pSHIFT_R=1, word0=0x01 -> p1[0]=0x20, p1[1..3]=0, bits 15:8 zero.
// - Full row [0][*]={1,1}, words 01,01,01,01 -> p1[0]=0x00 (XOR cancels); [0][0..2] only -> 0x80.
// - Shift 9 with Zc=8 -> term zero, oerr=1 stays high; iwstart mid-LOAD -> restart, oerr=1, only 4 outputs.
// - iclkena low 5 cycles mid-CALC -> outputs delayed exactly 5 cycles; ireset mid-CALC -> no further oval, ordy=1.

Source files
------------

// File: rtl/ldpc_3gpp_enc_p1_rot_pkg.sv
// Shared types and helpers for the 3GPP LDPC encoder p1 stage.
package ldpc_3gpp_enc_p1_rot_pkg;

  localparam int unsigned cMAX_ZC_W = 512;
  localparam int unsigned cMAX_LW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [cMAX_LW-1:0] shift;
  } invpsi_entry_t;

  // Low zc bits set; callers truncate to their data width.
  function automatic logic [cMAX_ZC_W-1:0] zc_mask(input int unsigned zc);
    logic [cMAX_ZC_W-1:0] m;
    for (int unsigned k = 0; k < cMAX_ZC_W; k++) m[k] = (k < zc);
    return m;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_zc_rot.sv
// Combinational cyclic rotator over the low zc bits of a pZC_W-bit word.
module ldpc_3gpp_enc_zc_rot
  import ldpc_3gpp_enc_p1_rot_pkg::*;
#(
  parameter int pZC_W    = 384,
  parameter int pZC_LW   = 9,
  parameter int pSHIFT_R = 1
) (
  input  logic [pZC_LW-1:0] zc,
  input  logic [pZC_LW-1:0] shift,
  input  logic [pZC_W-1:0]  din,
  output logic [pZC_W-1:0]  dout
);

  logic [pZC_W-1:0]   mask;
  logic [pZC_W-1:0]   xm;
  logic [2*pZC_W-1:0] dbl;
  logic [pZC_LW-1:0]  amt;

  always_comb begin
    mask = pZC_W'(zc_mask(32'(zc)));
    xm   = din & mask;
    // Two copies back to back turn the cyclic shift into a plain right shift.
    dbl  = {{pZC_W{1'b0}}, xm} | ({{pZC_W{1'b0}}, xm} << zc);
    if (pSHIFT_R != 0)
      amt = shift;
    else if (shift == '0)
      amt = '0;
    else
      amt = zc - shift;
    dout = pZC_W'(dbl >> amt) & mask;
  end

endmodule

// File: rtl/ldpc_3gpp_enc_p1_rot.sv
// p1 stage of the 3GPP LDPC encoder: buffers a frame of syndrome blocks and
// multiplies it by the invPsi quasi-cyclic matrix, one rotate+XOR per cycle.
module ldpc_3gpp_enc_p1_rot
  import ldpc_3gpp_enc_p1_rot_pkg::*;
#(
  parameter int pN_ROW   = 4,
  parameter int pZC_W    = 384,
  parameter int pZC_LW   = 9,
  parameter int pSHIFT_R = 1
) (
  input  logic                                  iclk,
  input  logic                                  ireset,
  input  logic                                  iclkena,
  input  logic [pZC_LW-1:0]                     iused_zc,
  input  logic                                  ibypass,
  input  logic [pN_ROW*pN_ROW*(1+pZC_LW)-1:0]   iinvPsi,
  input  logic                                  iwrite,
  input  logic                                  iwstart,
  input  logic [pZC_W-1:0]                      iwdat,
  output logic                                  ordy,
  output logic                                  obusy,
  output logic                                  oval,
  output logic                                  osof,
  output logic                                  oeof,
  output logic [((pN_ROW > 1) ? $clog2(pN_ROW) : 1)-1:0] oidx,
  output logic [pZC_W-1:0]                      odat,
  output logic                                  owrite2p2,
  output logic                                  owstart2p2,
  output logic [pZC_W-1:0]                      owdat2p2,
  output logic                                  oerr
);

  localparam int cIDX_W = (pN_ROW > 1) ? $clog2(pN_ROW) : 1;
  localparam int cENT_W = 1 + pZC_LW;
  localparam logic [cIDX_W-1:0] cLAST = cIDX_W'(pN_ROW - 1);

  state_t              state, state_d;
  logic [cIDX_W-1:0]   wcnt, widx, row, col;
  logic                wr_acc, wr_start, wr_last, byp_now;
  logic                calc_last_col, bad_shift, shift_ok;
  logic [pZC_LW-1:0]   zc_now, zc_q;
  logic                bypass_q;
  logic [pZC_W-1:0]    mask_now;
  invpsi_entry_t       psi_q [pN_ROW][pN_ROW];
  invpsi_entry_t       cur;
  logic [pZC_W-1:0]    buf_q [pN_ROW];
  logic [pZC_W-1:0]    rot_out, term, acc_p0;

  always_comb begin
    state_d  = state;
    wr_acc   = 1'b0;
    wr_start = 1'b0;
    widx     = wcnt;
    case (state)
      ST_IDLE: if (iwrite && iwstart) begin
        wr_acc   = 1'b1;
        wr_start = 1'b1;
        widx     = '0;
      end
      ST_LOAD: if (iwrite) begin
        wr_acc   = 1'b1;
        wr_start = iwstart;
        widx     = iwstart ? '0 : wcnt;
      end
      default: ;
    endcase
    byp_now  = wr_start ? ibypass : bypass_q;
    zc_now   = wr_start ? iused_zc : zc_q;
    mask_now = pZC_W'(zc_mask(32'(zc_now)));
    wr_last  = (widx == cLAST);
    if (wr_acc)
      state_d = wr_last ? (byp_now ? ST_IDLE : ST_CALC) : ST_LOAD;
    calc_last_col = (state == ST_CALC) && (col == cLAST);
    if (calc_last_col && (row == cLAST))
      state_d = ST_IDLE;
    ordy  = (state != ST_CALC);
    obusy = (state != ST_IDLE);
  end

  always_comb begin
    cur       = psi_q[row][col];
    shift_ok  = cur.shift < cMAX_LW'(zc_q);
    term      = (cur.valid && shift_ok) ? rot_out : '0;
    bad_shift = (state == ST_CALC) && cur.valid && !shift_ok;
  end

  ldpc_3gpp_enc_zc_rot #(
    .pZC_W    (pZC_W),
    .pZC_LW   (pZC_LW),
    .pSHIFT_R (pSHIFT_R)
  ) u_rot (
    .zc    (zc_q),
    .shift (pZC_LW'(cur.shift)),
    .din   (buf_q[col]),
    .dout  (rot_out)
  );

  // Control: FSM, counters, output strobes and sticky error.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      row   <= '0;
      col   <= '0;
      oval  <= 1'b0;
      osof  <= 1'b0;
      oeof  <= 1'b0;
      oerr  <= 1'b0;
    end else if (iclkena) begin
      state <= state_d;
      oval  <= 1'b0;
      osof  <= 1'b0;
      oeof  <= 1'b0;
      if (wr_acc) begin
        wcnt <= widx + cIDX_W'(1);
        row  <= '0;
        col  <= '0;
        if (byp_now) begin
          oval <= 1'b1;
          osof <= (widx == '0);
          oeof <= wr_last;
        end
        if (wr_start && (state == ST_LOAD))
          oerr <= 1'b1;
      end
      if (state == ST_CALC) begin
        col <= calc_last_col ? '0 : col + cIDX_W'(1);
        if (calc_last_col) begin
          row  <= row + cIDX_W'(1);
          oval <= 1'b1;
          osof <= (row == '0);
          oeof <= (row == cLAST);
        end
        if (bad_shift)
          oerr <= 1'b1;
      end
    end
  end

  // Data: word buffer, latched config, accumulator and output word.
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (wr_acc) begin
        buf_q[widx] <= iwdat;
        acc_p0      <= '0;
        if (wr_start) begin
          zc_q     <= iused_zc;
          bypass_q <= ibypass;
          for (int j = 0; j < pN_ROW; j++) begin
            for (int i = 0; i < pN_ROW; i++) begin
              psi_q[j][i].valid <= iinvPsi[(j*pN_ROW+i)*cENT_W + pZC_LW];
              psi_q[j][i].shift <= cMAX_LW'(iinvPsi[(j*pN_ROW+i)*cENT_W +: pZC_LW]);
            end
          end
        end
        if (byp_now) begin
          odat <= iwdat & mask_now;
          oidx <= widx;
        end
      end
      if (state == ST_CALC) begin
        if (calc_last_col) begin
          odat   <= acc_p0 ^ term;
          oidx   <= row;
          acc_p0 <= '0;
        end else begin
          acc_p0 <= acc_p0 ^ term;
        end
      end
    end
  end

  assign owrite2p2  = oval;
  assign owstart2p2 = osof;
  assign owdat2p2   = odat;

endmodule
